tlb_search_arbiter: RTL and testbench

- Shares the single TLB search port between three requesters: CP0 probe (TLBP), data-side translation (MEM stage) and instruction-fetch translation (IF stage).
- Grants one lookup at a time, drives the TLB search request from a registered copy, captures the result and returns it to the granted requester with a valid/ready handshake.
- Sits between the pipeline/CP0 and the TLB array. Blocks new lookups while a TLB write or read is in flight, and drops cancelled lookups on a per-requester flush.

---
 rtl/tlb_search_arbiter.sv | 93 +++++++++
 tb/tb_tlb_search_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/tlb_search_arbiter.sv
// tlb_search_arbiter: shares one TLB search port between probe, data and fetch requesters.
// Ports: clock/reset (sync, active-low); req_valid/req_ready/req_data per requester;
// resp_valid/resp_ready per requester with shared resp_data; flush cancels a requester's lookup;
// tlb_busy blocks new grants; tlb_request is the registered search key, tlb_responce the TLB result.
package tlb_params;
  typedef struct packed {
    logic [18:0] vpn;
    logic        odd_page;
    logic [7:0]  asid;
  } search_request_t;
  typedef struct packed {
    logic        found;
    logic [3:0]  index;
    logic [19:0] pfn;
    logic [2:0]  cache;
    logic        dirty;
    logic        valid;
  } search_result_t;
endpackage

module tlb_search_arbiter
  import tlb_params::*;
#(
  parameter int REQ_NUM        = 3,
  parameter int RR_RESET_INDEX = 2
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic            [REQ_NUM-1:0]       req_valid,
  output logic            [REQ_NUM-1:0]       req_ready,
  input  search_request_t [REQ_NUM-1:0]       req_data,
  output logic            [REQ_NUM-1:0]       resp_valid,
  input  logic            [REQ_NUM-1:0]       resp_ready,
  output search_result_t                      resp_data,
  input  logic            [REQ_NUM-1:0]       flush,
  input  logic                                tlb_busy,
  output search_request_t                     tlb_request,
  input  search_result_t                      tlb_responce
);
  localparam int IW = $clog2(REQ_NUM);
  typedef enum logic [1:0] {IDLE, SEARCH, RESP} state_t;
  state_t          state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d, rr_q, rr_d, grant;
  search_request_t req_q, req_d;
  search_result_t  res_q, res_d;
  logic [REQ_NUM-1:0] elig;
  logic            found, own_flush, handshake, accept, take;
  int              idx;
  always_comb begin
    elig      = req_valid & ~flush;
    own_flush = flush[owner_q];
    handshake = state_q == RESP && resp_ready[owner_q] && !own_flush;
    accept    = !tlb_busy && (state_q == IDLE || handshake);
    grant     = '0;
    found     = elig[0];
    idx       = 0;
    // round-robin scan over 1..REQ_NUM-1 starting at the pointer; requester 0 pre-empts the scan
    for (int k = 0; k < REQ_NUM - 1; k++) begin
      idx = (int'(rr_q) - 1 + k) % (REQ_NUM - 1) + 1;
      if (!found && elig[idx]) begin
        grant = IW'(idx);
        found = 1'b1;
      end
    end
    take       = accept && found;
    req_ready  = take ? REQ_NUM'(1) << grant : '0;
    resp_valid = state_q == RESP && !own_flush ? REQ_NUM'(1) << owner_q : '0;
    state_d    = state_q == SEARCH ? (own_flush ? IDLE : RESP)
               : state_q == RESP && (own_flush || handshake) ? IDLE : state_q;
    if (take) state_d = SEARCH;
    res_d      = state_q == SEARCH && !own_flush ? tlb_responce : res_q;
    req_d      = take ? req_data[grant] : req_q;
    owner_d    = take ? grant : owner_q;
    rr_d       = take && grant != '0 ? (grant == IW'(REQ_NUM - 1) ? IW'(1) : grant + IW'(1)) : rr_q;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= IW'(RR_RESET_INDEX);
      req_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      req_q   <= req_d;
      res_q   <= res_d;
    end
  end
  assign tlb_request = req_q;
  assign resp_data   = res_q;
endmodule

// File: tb/tb_tlb_search_arbiter.sv
// tb_tlb_search_arbiter: vector table, directed corner cases and random traffic against a transaction model.
module tb_tlb_search_arbiter;
  import tlb_params::*;
  logic clk = 1'b0, reset = 1'b0, tlb_busy = 1'b0;
  logic [2:0] req_valid = '0, req_ready, resp_valid, resp_ready = '0, flush = '0;
  search_request_t [2:0] req_data;
  search_result_t resp_data, tlb_responce;
  search_request_t tlb_request;
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;

  tlb_search_arbiter #(.REQ_NUM(3), .RR_RESET_INDEX(2)) dut (
    .clock(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .flush(flush),
    .tlb_busy(tlb_busy), .tlb_request(tlb_request), .tlb_responce(tlb_responce));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  // transaction model: one lookup slot with an age, priority list for requesters 1..2
  bit m_on, m_live, m_done;
  int m_owner, m_age, m_g;
  search_request_t m_req;
  search_result_t m_res;
  int rr_order[$];

  task automatic at_neg();
    logic [2:0] ev;
    bit responding;
    @(negedge clk);
    responding = m_live && m_age >= 2;
    ev = (responding && !flush[m_owner]) ? 3'(1 << m_owner) : 3'b0;
    m_done = responding && resp_ready[m_owner] && !flush[m_owner];
    m_g = -1;
    if ((!m_live || m_done) && !tlb_busy) begin
      if (req_valid[0] && !flush[0]) m_g = 0;
      else foreach (rr_order[k])
        if (m_g < 0 && req_valid[rr_order[k]] && !flush[rr_order[k]]) m_g = rr_order[k];
    end
    if (m_on) begin
      chk("req_ready", 64'(req_ready), m_g >= 0 ? 64'(1 << m_g) : 64'd0);
      chk("resp_valid", 64'(resp_valid), 64'(ev));
      if (ev != 0) chk("resp_data", 64'(resp_data), 64'(m_res));
      chk("tlb_request", 64'(tlb_request), 64'(m_req));
    end
  endtask

  task automatic at_pos();
    @(posedge clk);
    if (!reset) begin
      m_on = 1; m_live = 0; m_req = '0; m_res = '0; rr_order = {2, 1};
    end else begin
      if (m_live) begin
        if (m_age == 1) begin
          if (flush[m_owner]) m_live = 0;
          else begin m_res = tlb_responce; m_age = 2; end
        end else if (flush[m_owner] || m_done) m_live = 0;
      end
      if (m_g >= 0) begin
        m_live = 1; m_owner = m_g; m_age = 1; m_req = req_data[m_g];
        if (m_g > 0) while (rr_order[$] != m_g) rr_order.push_back(rr_order.pop_front());
      end
    end
    #1;
  endtask

  task automatic step(input logic [2:0] rv, input logic [2:0] rr, input logic [2:0] fl, input logic busy);
    req_valid = rv; resp_ready = rr; flush = fl; tlb_busy = busy;
    at_neg();
  endtask

  typedef struct {
    bit rstn; logic [2:0] rv, rr, fl; bit busy; logic [2:0] er, ev; bit en;
  } vec_t;
  vec_t vt[$];
  search_result_t held;

  initial begin
    req_data[0] = '{vpn: 19'h00AAA, odd_page: 1'b0, asid: 8'h01};
    req_data[1] = '{vpn: 19'h12345, odd_page: 1'b0, asid: 8'h05};
    req_data[2] = '{vpn: 19'h7BCDE, odd_page: 1'b1, asid: 8'h09};
    tlb_responce = '{found: 1'b1, index: 4'd4, pfn: 20'h0ABCD, cache: 3'd3, dirty: 1'b1, valid: 1'b1};
    vt = '{
      '{0, 3'b000, 3'b000, 3'b000, 0, 3'b000, 3'b000, 0},
      '{0, 3'b000, 3'b000, 3'b000, 0, 3'b000, 3'b000, 1},
      '{1, 3'b010, 3'b000, 3'b000, 0, 3'b010, 3'b000, 1},
      '{1, 3'b000, 3'b000, 3'b000, 0, 3'b000, 3'b000, 1},
      '{1, 3'b000, 3'b010, 3'b000, 0, 3'b000, 3'b010, 1},
      '{1, 3'b000, 3'b000, 3'b000, 0, 3'b000, 3'b000, 1},
      '{1, 3'b111, 3'b111, 3'b000, 0, 3'b001, 3'b000, 1},
      '{1, 3'b111, 3'b111, 3'b000, 0, 3'b000, 3'b000, 1},
      '{1, 3'b111, 3'b111, 3'b000, 0, 3'b001, 3'b001, 1},
      '{1, 3'b111, 3'b111, 3'b000, 0, 3'b000, 3'b000, 1},
      '{1, 3'b110, 3'b111, 3'b000, 0, 3'b100, 3'b001, 1},
      '{1, 3'b110, 3'b111, 3'b000, 0, 3'b000, 3'b000, 1},
      '{1, 3'b110, 3'b111, 3'b000, 0, 3'b010, 3'b100, 1},
      '{1, 3'b110, 3'b111, 3'b000, 0, 3'b000, 3'b000, 1},
      '{1, 3'b110, 3'b111, 3'b000, 0, 3'b100, 3'b010, 1},
      '{1, 3'b110, 3'b111, 3'b000, 0, 3'b000, 3'b000, 1},
      '{1, 3'b110, 3'b111, 3'b000, 0, 3'b010, 3'b100, 1},
      '{1, 3'b110, 3'b111, 3'b000, 0, 3'b000, 3'b000, 1},
      '{1, 3'b000, 3'b111, 3'b000, 0, 3'b000, 3'b010, 1},
      '{1, 3'b000, 3'b000, 3'b000, 0, 3'b000, 3'b000, 1}
    };
    #1;
    foreach (vt[i]) begin
      reset = vt[i].rstn;
      step(vt[i].rv, vt[i].rr, vt[i].fl, vt[i].busy);
      if (vt[i].en) begin
        chk($sformatf("vec%0d_ready", i), 64'(req_ready), 64'(vt[i].er));
        chk($sformatf("vec%0d_rvalid", i), 64'(resp_valid), 64'(vt[i].ev));
      end
      if (i == 3) chk("t1_vpn", 64'(tlb_request.vpn), 64'h12345);
      if (i == 4) chk("t1_index", 64'(resp_data.index), 64'd4);
      at_pos();
    end
    // backpressure: req 2 holds its response 5 cycles while req 1 waits
    step(3'b100, 3'b000, 3'b000, 0); chk("bp_accept", 64'(req_ready), 64'b100); at_pos();
    step(3'b010, 3'b000, 3'b000, 0); at_pos();
    held = tlb_responce;
    for (int c = 0; c < 5; c++) begin
      tlb_responce = search_result_t'($urandom);
      step(3'b010, 3'b000, 3'b000, 0);
      chk("bp_data", 64'(resp_data), 64'(held));
      chk("bp_noready", 64'(req_ready), 64'd0);
      at_pos();
    end
    step(3'b010, 3'b100, 3'b000, 0); chk("bp_hs_ready", 64'(req_ready), 64'b010); at_pos();
    step(3'b000, 3'b000, 3'b000, 0); at_pos();
    step(3'b000, 3'b010, 3'b000, 0); at_pos();
    // flush during search, then flush during response
    step(3'b010, 3'b000, 3'b000, 0); at_pos();
    step(3'b000, 3'b000, 3'b010, 0); at_pos();
    step(3'b001, 3'b000, 3'b000, 0);
    chk("fl_norv", 64'(resp_valid), 64'd0); chk("fl_idle", 64'(req_ready), 64'b001); at_pos();
    step(3'b000, 3'b000, 3'b000, 0); at_pos();
    step(3'b100, 3'b001, 3'b001, 0);
    chk("fl_resp_drop", 64'(resp_valid), 64'd0); chk("fl_resp_noacc", 64'(req_ready), 64'd0); at_pos();
    step(3'b100, 3'b000, 3'b000, 1); at_pos();
    // busy: in-flight lookup completes, no grant until busy falls
    for (int c = 0; c < 4; c++) begin
      step(3'b100, 3'b100, 3'b000, 1); chk("busy_noready", 64'(req_ready), 64'd0); at_pos();
    end
    step(3'b000, 3'b000, 3'b000, 0); at_pos();
    step(3'b010, 3'b000, 3'b000, 0); at_pos();
    for (int c = 0; c < 4; c++) begin
      step(3'b100, 3'b010, 3'b000, 1);
      if (c == 1) chk("busy_inflight_rv", 64'(resp_valid), 64'b010);
      chk("busy_noready2", 64'(req_ready), 64'd0); at_pos();
    end
    step(3'b100, 3'b000, 3'b000, 0); chk("busy_fall", 64'(req_ready), 64'b100); at_pos();
    // reset during search clears the request register and the rr pointer
    step(3'b000, 3'b100, 3'b000, 0); at_pos();
    step(3'b000, 3'b100, 3'b000, 0); at_pos();
    step(3'b100, 3'b000, 3'b000, 0); at_pos();
    reset = 1'b0; step(3'b000, 3'b000, 3'b000, 0); at_pos();
    reset = 1'b1; step(3'b110, 3'b000, 3'b000, 0);
    chk("rst_rv", 64'(resp_valid), 64'd0); chk("rst_req", 64'(tlb_request), 64'd0);
    chk("rst_rr", 64'(req_ready), 64'b100); at_pos();
    // random traffic
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 99) != 0);
      for (int r = 0; r < 3; r++) req_data[r] = search_request_t'($urandom);
      tlb_responce = search_result_t'($urandom);
      step(3'($urandom), 3'($urandom), ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b000,
           $urandom_range(0, 5) == 0);
      at_pos();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
